// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks one functional-unit result per cycle and registers it
// onto the common data bus (CDB) one cycle after the grant.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   flush             - squash: no new grant this cycle, priority held
//   req_valid         - per-requester "result ready"
//   req_tag/req_data  - packed per-requester tag/data (i at [i*W +: W])
//   req_grant         - one-hot combinational acceptance
//   cdb_valid/tag/data/src - registered broadcast
//
// Build option: define CDB_ARB_RR_EN for round-robin arbitration; without
// it the lowest-indexed valid requester always wins and no pointer exists.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_grant,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [DATA_W-1:0]            cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]   cdb_src
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [TAG_W-1:0]  tag_arr  [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign tag_arr[i]  = req_tag[i*TAG_W +: TAG_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    logic             found;
    logic [SRC_W-1:0] win_idx;
    logic             grant_en;

`ifdef CDB_ARB_RR_EN
    localparam logic [SRC_W:0] NREQ = (SRC_W+1)'(NUM_REQ);

    logic [SRC_W-1:0] ptr_q;
    logic [SRC_W-1:0] ptr_d;
    logic [SRC_W:0]   probe;

    // Search ascends from ptr and wraps modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        probe   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (probe >= NREQ) begin
                probe = probe - NREQ;
            end
            if (!found && req_valid[probe[SRC_W-1:0]]) begin
                found   = 1'b1;
                win_idx = probe[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en) begin
            if (win_idx == SRC_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[SRC_W'(k)]) begin
                found   = 1'b1;
                win_idx = SRC_W'(k);
            end
        end
    end
`endif

    // Reset and flush both suppress the grant, so a pending transfer is
    // simply not accepted and the requester keeps holding it.
    assign grant_en = found && !rst && !flush;

    always_comb begin
        req_grant = '0;
        if (grant_en) begin
            req_grant = NUM_REQ'(1) << win_idx;
        end
    end

    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;

    // Payload holds when nothing is granted; only valid drops.
    always_comb begin
        valid_d = grant_en;
        tag_d   = tag_q;
        data_d  = data_q;
        src_d   = src_q;
        if (grant_en) begin
            tag_d  = tag_arr[win_idx];
            data_d = data_arr[win_idx];
            src_d  = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, hand sequences and random
// stimulus against an arithmetic reference model of the arbiter.
module tb_cdb_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [19:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_grant;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_grant (req_grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    int          m_ptr = 0;
    logic        m_cv;
    logic [4:0]  m_tag;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    logic [3:0]  m_grant;
    logic [3:0]  seen_grant;

    // Rotate so index p sits at bit 0, isolate lowest set bit, rotate back.
    function automatic logic [3:0] model_grant(input logic r, input logic f,
                                               input logic [3:0] v,
                                               input int p);
        logic [7:0] dbl;
        logic [7:0] sh;
        logic [3:0] rot;
        logic [3:0] low;
        if (r || f || v == 4'd0) return 4'd0;
        dbl = {v, v};
        sh  = dbl >> p;
        rot = sh[3:0];
        low = rot & (~rot + 4'd1);
        sh  = {4'd0, low} << p;
        return sh[3:0] | sh[7:4];
    endfunction

    task automatic step(input logic r, input logic f, input logic [3:0] v,
                        input logic [19:0] t, input logic [127:0] d);
        int s;
        @(negedge clk);
        rst = r;
        flush = f;
        req_valid = v;
        req_tag = t;
        req_data = d;
        #1;
        seen_grant = req_grant;
        m_grant = model_grant(r, f, v, m_ptr);
        @(posedge clk);
        if (r) begin
            m_cv = 1'b0;
            m_tag = '0;
            m_data = '0;
            m_src = '0;
            m_ptr = 0;
        end else if (m_grant != 4'd0) begin
            s = $clog2(m_grant);
            m_cv = 1'b1;
            m_src = 2'(s);
            m_tag = t[s*5 +: 5];
            m_data = d[s*32 +: 32];
`ifdef CDB_ARB_RR_EN
            m_ptr = (s + 1) % N;
`endif
        end else begin
            m_cv = 1'b0;
        end
        #1;
    endtask

    typedef struct {
        logic       r;
        logic       f;
        logic [3:0] v;
        logic [3:0] g;
        logic       cv;
        logic [1:0] src;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic f, input logic [3:0] v,
                       input logic [3:0] g, input logic cv,
                       input logic [1:0] src);
        vec_t e;
        e.r = r;
        e.f = f;
        e.v = v;
        e.g = g;
        e.cv = cv;
        e.src = src;
        tbl.push_back(e);
    endtask

    function automatic logic [4:0] mk_tag(input int row, input int i);
        return 5'((row * 3 + i + 1) % 32);
    endfunction

    function automatic logic [31:0] mk_data(input int row, input int i);
        return 32'hC0DE_0000 + 32'(row * 256 + i);
    endfunction

    logic [19:0]  t;
    logic [127:0] d;
    logic [4:0]   e_tag;
    logic [31:0]  e_data;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_tag = '0;
        req_data = '0;
        e_tag = '0;
        e_data = '0;

`ifdef CDB_ARB_RR_EN
        add(1, 0, 4'b1111, 4'b0000, 0, 0);
        add(1, 0, 4'b1111, 4'b0000, 0, 0);
        add(0, 0, 4'b1111, 4'b0001, 1, 0);
        add(0, 0, 4'b1111, 4'b0010, 1, 1);
        add(0, 0, 4'b1111, 4'b0100, 1, 2);
        add(0, 0, 4'b1111, 4'b1000, 1, 3);
        add(0, 0, 4'b1111, 4'b0001, 1, 0);
        add(0, 0, 4'b1111, 4'b0010, 1, 1);
        add(0, 0, 4'b1111, 4'b0100, 1, 2);
        add(0, 0, 4'b1111, 4'b1000, 1, 3);
        add(0, 0, 4'b0010, 4'b0010, 1, 1);
        add(0, 1, 4'b0110, 4'b0000, 0, 1);
        add(0, 0, 4'b0110, 4'b0100, 1, 2);
        add(0, 0, 4'b1001, 4'b1000, 1, 3);
        add(0, 0, 4'b1001, 4'b0001, 1, 0);
        add(0, 0, 4'b1001, 4'b1000, 1, 3);
`else
        add(1, 0, 4'b1111, 4'b0000, 0, 0);
        add(1, 0, 4'b1111, 4'b0000, 0, 0);
        add(0, 0, 4'b1111, 4'b0001, 1, 0);
        add(0, 0, 4'b1010, 4'b0010, 1, 1);
        add(0, 0, 4'b1010, 4'b0010, 1, 1);
        add(0, 0, 4'b1010, 4'b0010, 1, 1);
        add(0, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 0, 4'b1000, 4'b1000, 1, 3);
        add(0, 0, 4'b0010, 4'b0010, 1, 1);
        add(0, 1, 4'b0110, 4'b0000, 0, 1);
        add(0, 0, 4'b0110, 4'b0010, 1, 1);
        add(1, 1, 4'b1111, 4'b0000, 0, 0);
        add(0, 0, 4'b0100, 4'b0100, 1, 2);
`endif

        for (int n = 0; n < tbl.size(); n++) begin
            for (int i = 0; i < N; i++) begin
                t[i*5 +: 5] = mk_tag(n, i);
                d[i*32 +: 32] = mk_data(n, i);
            end
            step(tbl[n].r, tbl[n].f, tbl[n].v, t, d);
            if (tbl[n].r) begin
                e_tag = '0;
                e_data = '0;
            end else if (tbl[n].cv) begin
                e_tag = mk_tag(n, int'(tbl[n].src));
                e_data = mk_data(n, int'(tbl[n].src));
            end
            chk($sformatf("tbl%0d_grant", n), 32'(seen_grant), 32'(tbl[n].g));
            chk($sformatf("tbl%0d_cv", n), 32'(cdb_valid), 32'(tbl[n].cv));
            chk($sformatf("tbl%0d_src", n), 32'(cdb_src), 32'(tbl[n].src));
            chk($sformatf("tbl%0d_tag", n), 32'(cdb_tag), 32'(e_tag));
            chk($sformatf("tbl%0d_data", n), cdb_data, e_data);
        end

        // Single requester with a known payload
        step(1, 0, 4'b0000, '0, '0);
        t = '0;
        d = '0;
        t[14:10] = 5'd9;
        d[95:64] = 32'hDEADBEEF;
        step(0, 0, 4'b0100, t, d);
        chk("single_grant", 32'(seen_grant), 32'b0100);
        chk("single_cv", 32'(cdb_valid), 32'd1);
        chk("single_tag", 32'(cdb_tag), 32'd9);
        chk("single_data", cdb_data, 32'hDEADBEEF);
        chk("single_src", 32'(cdb_src), 32'd2);

        // Back-to-back from one requester
        for (int k = 0; k < 3; k++) begin
            t = '0;
            d = '0;
            t[4:0] = 5'(k + 20);
            d[31:0] = 32'h1000 + 32'(k);
            step(0, 0, 4'b0001, t, d);
            chk($sformatf("b2b%0d_grant", k), 32'(seen_grant), 32'b0001);
            chk($sformatf("b2b%0d_cv", k), 32'(cdb_valid), 32'd1);
            chk($sformatf("b2b%0d_tag", k), 32'(cdb_tag), 32'(k + 20));
        end

        // Transfer pending at reset is dropped, never broadcast
        t = '0;
        t[9:5] = 5'd17;
        step(1, 0, 4'b0010, t, '0);
        chk("rstdrop_grant", 32'(seen_grant), 32'd0);
        step(0, 0, 4'b0000, t, '0);
        chk("rstdrop_cv", 32'(cdb_valid), 32'd0);
        chk("rstdrop_tag", 32'(cdb_tag), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic       r;
            logic       f;
            logic [3:0] v;
            r = ($urandom_range(0, 31) == 0);
            f = ($urandom_range(0, 7) == 0);
            v = 4'($urandom);
            t = 20'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            step(r, f, v, t, d);
            chk("rnd_grant", 32'(seen_grant), 32'(m_grant));
            chk("rnd_cv", 32'(cdb_valid), 32'(m_cv));
            chk("rnd_src", 32'(cdb_src), 32'(m_src));
            chk("rnd_tag", 32'(cdb_tag), 32'(m_tag));
            chk("rnd_data", cdb_data, m_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of functional-unit requesters (2..8).
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the reservation-station tag width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the result data width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 The block SHALL have port flush, input, 1, meaning squash: grant nothing this cycle.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ, meaning requester i holds a result.
REQ-008 The block SHALL have port req_tag, input, NUM_REQ*TAG_W, meaning the packed tags (requester i at bits [i*TAG_W +: TAG_W]).
REQ-009 The block SHALL have port req_data, input, NUM_REQ*DATA_W, meaning the packed results (same packing).
REQ-010 The block SHALL have port req_grant, output, NUM_REQ, meaning one-hot acceptance; combinational, same cycle.
REQ-011 The block SHALL have port cdb_valid, output, 1, meaning a registered broadcast is valid.
REQ-012 The block SHALL have port cdb_tag, output, TAG_W, meaning the registered broadcast tag.
REQ-013 The block SHALL have port cdb_data, output, DATA_W, meaning the registered broadcast data.
REQ-014 The block SHALL have port cdb_src, output, clog2(NUM_REQ), meaning the index of the broadcasting requester.

Function
REQ-015 The block SHALL assert at most one req_grant bit per cycle, and only for a requester with req_valid=1.
REQ-016 A transfer SHALL occur when req_valid[i] and req_grant[i] are both 1; the requester SHALL hold tag/data stable until granted and drop or replace them on the next cycle.
REQ-017 If any req_valid bit is 1 and flush=0, the block SHALL grant exactly one requester (work-conserving).
REQ-018 The granted tag/data SHALL appear on cdb_tag/cdb_data, with cdb_valid=1 and cdb_src=i, exactly one cycle after the grant (latency 1).
REQ-019 In a cycle with no grant, cdb_valid SHALL go 0 on the next edge; cdb_tag/cdb_data/cdb_src SHALL hold their previous values.
REQ-020 With flush=1, req_grant SHALL be all-zero, cdb_valid SHALL be 0 on the next edge, and the priority pointer SHALL remain unchanged.
REQ-021 A broadcast already registered at the time of flush SHALL still be presented for its one cycle; flush affects only new grants.
REQ-022 The round-robin priority pointer ptr SHALL start its search at index ptr and ascend modulo NUM_REQ; the first valid requester wins.
REQ-023 After a grant to i, ptr SHALL become (i+1) mod NUM_REQ; this wraps from NUM_REQ-1 to 0. Without a grant, ptr SHALL hold.
REQ-024 With all NUM_REQ requesters continuously valid, each SHALL be granted exactly once in every NUM_REQ consecutive cycles.
REQ-025 A single continuously-valid requester SHALL be granted every cycle, giving back-to-back cdb_valid=1.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0 and ptr=0.
REQ-027 While rst=1, req_grant SHALL be all-zero regardless of req_valid; a transfer pending at reset SHALL be lost, not broadcast.
REQ-028 rst SHALL take precedence over flush and over all requests.

Configuration
REQ-029 With macro CDB_ARB_RR_EN defined, arbitration SHALL be round-robin as specified in REQ-022 to REQ-024.
REQ-030 Without CDB_ARB_RR_EN, arbitration SHALL be fixed-priority: the lowest index wins; ptr logic SHALL be absent; and REQ-024 does not apply.

Verification
REQ-031 Reset: rst=1 for 2 cycles with req_valid=4'b1111 -> req_grant=0, cdb_valid=0, cdb_tag=0, cdb_data=0; after release, the first grant goes to index 0.
REQ-032 Single requester: req_valid=4'b0100, tag 5'd9, data 32'hDEADBEEF -> req_grant=4'b0100 same cycle; next cycle cdb_valid=1, cdb_tag=9, cdb_data=32'hDEADBEEF, cdb_src=2.
REQ-033 Fairness (RR_EN): req_valid=4'b1111 held for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; cdb_valid stays 1 from cycle 2 onward.
REQ-034 Wrap: ptr=3, req_valid=4'b1001 -> grant 3, then grant 0, then grant 3 with request held.
REQ-035 Flush: grant to 1 in cycle N, flush=1 in cycle N+1 with req_valid=4'b0110 -> cdb_valid=1 in N+1 (src 1), cdb_valid=0 in N+2, and the grant after flush goes to 2.
REQ-036 Fixed priority (no RR_EN): req_valid=4'b1010 held for 3 cycles -> grant 1 every cycle; requester 3 is never granted.
